// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-limited sequential prefetcher feeding a PC-tagged instruction queue to the IDU
module ifu_prefetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid_icache_o,
  input  logic                  req_ready_icache_i,
  output logic [ADDR_WIDTH-1:0] req_addr_icache_o,
  input  logic                  resp_valid_icache_i,
  input  logic [INST_WIDTH-1:0] resp_instr_icache_i,
  output logic                  instr_valid_idu_o,
  input  logic                  instr_ready_idu_i,
  output logic [INST_WIDTH-1:0] instr_idu_o,
  output logic [ADDR_WIDTH-1:0] pc_idu_o,
  input  logic                  redirect_valid_exeu_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_exeu_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INST_WIDTH / 8);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] pc_mem [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] ins_mem [FIFO_DEPTH];
  logic redir, issue, push, pop;
  assign redir = redirect_valid_exeu_i;
  assign redir_pc = redirect_pc_exeu_i & ~ADDR_WIDTH'(3);
  assign req_valid_icache_o = !rst && !redir && ({1'b0, cnt_q} + {1'b0, out_q} < DEPTH);
  assign req_addr_icache_o = fetch_pc_q;
  assign issue = req_valid_icache_o && req_ready_icache_i;
  assign push = resp_valid_icache_i && !redir && drop_q == '0;
  assign instr_valid_idu_o = !rst && cnt_q != '0;
  assign pop = instr_valid_idu_o && instr_ready_idu_i;
  assign instr_idu_o = ins_mem[head_q];
  assign pc_idu_o = pc_mem[head_q];
  always_comb begin
    out_d = out_q + CW'(issue) - CW'(resp_valid_icache_i);
    drop_d = redir ? out_d : drop_q - CW'(resp_valid_icache_i && drop_q != '0);
    fetch_pc_d = redir ? redir_pc : issue ? fetch_pc_q + INC : fetch_pc_q;
    resp_pc_d = redir ? redir_pc : push ? resp_pc_q + INC : resp_pc_q;
    cnt_d = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
    head_d = redir ? '0 : head_q + PW'(pop);
    tail_d = redir ? '0 : tail_q + PW'(push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q] <= resp_pc_q;
      ins_mem[tail_q] <= resp_instr_icache_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) assert (cnt_q != CW'(FIFO_DEPTH));
  end
endmodule
